// File: rtl/board_pkg.sv
// Shared constants, FSM state type and width helpers for the board cursor controller.
package board_pkg;

  localparam int unsigned CELL_EMPTY = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Cell width: encodes empty plus one code per player.
  function automatic int unsigned cw_f(input int unsigned players);
    return $clog2(players + 1);
  endfunction

  function automatic int unsigned iw_f(input int unsigned cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

  function automatic int unsigned pw_f(input int unsigned players);
    return (players > 1) ? $clog2(players) : 1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw active-low button plus falling-edge press detector.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic s1_q, s2_q, prev_q;

  // Flops reset to the released level so reset itself never looks like a press edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= btn_n;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign press = prev_q & ~s2_q;

endmodule

// File: rtl/board_cursor_ctrl.sv
// Grid-game board store with button-driven cursor and turn-checked mark commit
// reported to the game FSM over a valid/ack handshake.
module board_cursor_ctrl
  import board_pkg::*;
#(
  parameter int unsigned ROWS    = 3,
  parameter int unsigned COLS    = 3,
  parameter int unsigned PLAYERS = 2,
  localparam int unsigned CELLS  = ROWS * COLS,
  localparam int unsigned CW     = cw_f(PLAYERS),
  localparam int unsigned IW     = iw_f(CELLS),
  localparam int unsigned PW     = pw_f(PLAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_step_n,
  input  logic                  btn_row_n,
  input  logic [PLAYERS-1:0]    btn_mark_n,
  input  logic [PW-1:0]         turn_player,
  input  logic                  turn_en,
  input  logic                  board_clr,
  input  logic                  mark_ack,
  output logic [CELLS*CW-1:0]   board,
  output logic [IW-1:0]         cursor,
  output logic                  mark_valid,
  output logic [IW-1:0]         mark_idx,
  output logic [PW-1:0]         mark_player,
  output logic                  reject,
  output logic [IW:0]           filled,
  output logic                  board_full
);

  logic                step_press, row_press;
  logic [PLAYERS-1:0]  mark_press;

  btn_sync_edge u_step (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_step_n),
    .press (step_press)
  );

  btn_sync_edge u_row (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_row_n),
    .press (row_press)
  );

  for (genvar p = 0; p < PLAYERS; p++) begin : g_mark
    btn_sync_edge u_mark (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_mark_n[p]),
      .press (mark_press[p])
    );
  end

  logic [CELLS*CW-1:0] board_q, board_d;
  logic [IW-1:0]       cursor_q, cursor_d;
  logic [IW-1:0]       mark_idx_q, mark_idx_d;
  logic [PW-1:0]       mark_player_q, mark_player_d;
  logic [IW:0]         filled_q, filled_d;
  logic                reject_q, reject_d;
  state_e              state_q, state_d;

  logic [31:0]         cur_int;
  logic [CW-1:0]       cell_cur;
  logic [PLAYERS-1:0]  mark_sel;

  always_comb begin
    board_d       = board_q;
    cursor_d      = cursor_q;
    mark_idx_d    = mark_idx_q;
    mark_player_d = mark_player_q;
    filled_d      = filled_q;
    reject_d      = 1'b0;
    state_d       = state_q;
    cur_int       = 32'(cursor_q);
    cell_cur      = board_q[cursor_q*CW +: CW];
    mark_sel      = PLAYERS'(1) << turn_player;

    if (board_clr) begin
      board_d  = '0;
      filled_d = '0;
      cursor_d = IW'(CELLS - 1);
      state_d  = ST_IDLE;
    end else begin
      // Row beats step when both land in the same cycle.
      if (row_press) begin
        if (cur_int < COLS) cursor_d = IW'(cur_int + CELLS - COLS);
        else                cursor_d = IW'(cur_int - COLS);
      end else if (step_press) begin
        cursor_d = (cursor_q == '0) ? IW'(CELLS - 1) : cursor_q - IW'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if ((|mark_press) && turn_en) begin
            // Exact match against the one-hot turn bit also rules out multi-button presses.
            if ((mark_press == mark_sel) && (cell_cur == CW'(CELL_EMPTY))) begin
              board_d[cursor_q*CW +: CW] = CW'(turn_player) + CW'(1);
              filled_d      = filled_q + (IW+1)'(1);
              mark_idx_d    = cursor_q;
              mark_player_d = turn_player;
              state_d       = ST_PEND;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (|mark_press) reject_d = 1'b1;
          if (mark_ack)    state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board_q       <= '0;
      cursor_q      <= IW'(CELLS - 1);
      mark_idx_q    <= '0;
      mark_player_q <= '0;
      filled_q      <= '0;
      reject_q      <= 1'b0;
      state_q       <= ST_IDLE;
    end else begin
      board_q       <= board_d;
      cursor_q      <= cursor_d;
      mark_idx_q    <= mark_idx_d;
      mark_player_q <= mark_player_d;
      filled_q      <= filled_d;
      reject_q      <= reject_d;
      state_q       <= state_d;
    end
  end

  assign board       = board_q;
  assign cursor      = cursor_q;
  assign mark_valid  = (state_q == ST_PEND);
  assign mark_idx    = mark_idx_q;
  assign mark_player = mark_player_q;
  assign reject      = reject_q;
  assign filled      = filled_q;
  assign board_full  = (filled_q == (IW+1)'(CELLS));

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Directed bench: a 3x3/2-player instance and a 4x5/3-player instance driven by raw buttons.
module tb_board_cursor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_step_n, a_row_n, a_turn_en, a_clr, a_ack;
  logic [1:0]  a_mark_n;
  logic [0:0]  a_turn;
  logic [17:0] a_board;
  logic [3:0]  a_cursor, a_midx;
  logic        a_mv, a_reject, a_full;
  logic [0:0]  a_mplayer;
  logic [4:0]  a_filled;

  logic        b_step_n, b_row_n, b_turn_en, b_clr, b_ack;
  logic [2:0]  b_mark_n;
  logic [1:0]  b_turn;
  logic [39:0] b_board;
  logic [4:0]  b_cursor, b_midx;
  logic        b_mv, b_reject, b_full;
  logic [1:0]  b_mplayer;
  logic [5:0]  b_filled;

  logic [39:0] b_exp;
  int          n_checks = 0;
  int          n_fail   = 0;

  board_cursor_ctrl u_dut_a (
    .clk(clk), .rst(rst), .btn_step_n(a_step_n), .btn_row_n(a_row_n), .btn_mark_n(a_mark_n),
    .turn_player(a_turn), .turn_en(a_turn_en), .board_clr(a_clr), .mark_ack(a_ack),
    .board(a_board), .cursor(a_cursor), .mark_valid(a_mv), .mark_idx(a_midx),
    .mark_player(a_mplayer), .reject(a_reject), .filled(a_filled), .board_full(a_full)
  );

  board_cursor_ctrl #(.ROWS(4), .COLS(5), .PLAYERS(3)) u_dut_b (
    .clk(clk), .rst(rst), .btn_step_n(b_step_n), .btn_row_n(b_row_n), .btn_mark_n(b_mark_n),
    .turn_player(b_turn), .turn_en(b_turn_en), .board_clr(b_clr), .mark_ack(b_ack),
    .board(b_board), .cursor(b_cursor), .mark_valid(b_mv), .mark_idx(b_midx),
    .mark_player(b_mplayer), .reject(b_reject), .filled(b_filled), .board_full(b_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Buttons stay held afterwards; sampling point is just after the action edge.
  task automatic press_a(input logic s, input logic r, input logic [1:0] m);
    a_step_n = ~s; a_row_n = ~r; a_mark_n = ~m;
    tick(3);
  endtask

  task automatic press_b(input logic s, input logic r, input logic [2:0] m);
    b_step_n = ~s; b_row_n = ~r; b_mark_n = ~m;
    tick(3);
  endtask

  task automatic release_all();
    a_step_n = 1'b1; a_row_n = 1'b1; a_mark_n = '1;
    b_step_n = 1'b1; b_row_n = 1'b1; b_mark_n = '1;
    tick(3);
  endtask

  task automatic step_to_a(input int tgt);
    for (int i = 0; i < 12 && int'(a_cursor) != tgt; i++) begin
      press_a(1'b1, 1'b0, 2'b00);
      release_all();
    end
    chk("a_step_to", 64'(a_cursor), 64'(tgt));
  endtask

  task automatic step_to_b(input int tgt);
    for (int i = 0; i < 25 && int'(b_cursor) != tgt; i++) begin
      press_b(1'b1, 1'b0, 3'b000);
      release_all();
    end
    chk("b_step_to", 64'(b_cursor), 64'(tgt));
  endtask

  initial begin
    int p;
    int idx;
    rst = 1'b1;
    a_step_n = 1'b1; a_row_n = 1'b1; a_mark_n = '1;
    b_step_n = 1'b1; b_row_n = 1'b1; b_mark_n = '1;
    a_turn = '0; a_turn_en = 1'b0; a_clr = 1'b0; a_ack = 1'b0;
    b_turn = '0; b_turn_en = 1'b0; b_clr = 1'b0; b_ack = 1'b0;
    b_exp = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    chk("a_rst_cursor", 64'(a_cursor), 64'd8);
    chk("a_rst_board", 64'(a_board), 64'd0);
    chk("a_rst_filled", 64'(a_filled), 64'd0);
    chk("a_rst_valid", 64'(a_mv), 64'd0);
    chk("a_rst_idx", 64'(a_midx), 64'd0);
    chk("a_rst_player", 64'(a_mplayer), 64'd0);
    chk("a_rst_reject", 64'(a_reject), 64'd0);
    chk("a_rst_full", 64'(a_full), 64'd0);
    chk("b_rst_cursor", 64'(b_cursor), 64'd19);
    chk("b_rst_board", 64'(b_board), 64'd0);

    for (int i = 0; i < 9; i++) begin
      press_a(1'b1, 1'b0, 2'b00);
      chk("a_step_seq", 64'(a_cursor), (i < 8) ? 64'(7 - i) : 64'd8);
      release_all();
    end

    press_a(1'b1, 1'b0, 2'b00);
    tick(17);
    chk("a_step_hold", 64'(a_cursor), 64'd7);
    release_all();

    step_to_a(1);
    press_a(1'b0, 1'b1, 2'b00);
    chk("a_row_wrap_1", 64'(a_cursor), 64'd7);
    release_all();
    step_to_a(4);
    press_a(1'b0, 1'b1, 2'b00);
    chk("a_row_4", 64'(a_cursor), 64'd1);
    release_all();
    step_to_a(5);
    press_a(1'b1, 1'b1, 2'b00);
    chk("a_row_over_step", 64'(a_cursor), 64'd2);
    release_all();

    step_to_a(8);
    a_turn_en = 1'b1; a_turn = 1'b0;
    press_a(1'b0, 1'b0, 2'b01);
    chk("a_mark0_board", 64'(a_board), 64'h10000);
    chk("a_mark0_valid", 64'(a_mv), 64'd1);
    chk("a_mark0_idx", 64'(a_midx), 64'd8);
    chk("a_mark0_player", 64'(a_mplayer), 64'd0);
    chk("a_mark0_filled", 64'(a_filled), 64'd1);
    chk("a_mark0_noreject", 64'(a_reject), 64'd0);
    release_all();
    a_ack = 1'b1; tick(1); a_ack = 1'b0;
    chk("a_ack_valid", 64'(a_mv), 64'd0);

    a_turn = 1'b1;
    press_a(1'b0, 1'b0, 2'b10);
    chk("a_occ_reject", 64'(a_reject), 64'd1);
    chk("a_occ_board", 64'(a_board), 64'h10000);
    tick(1);
    chk("a_reject_1cyc", 64'(a_reject), 64'd0);
    release_all();

    press_a(1'b1, 1'b0, 2'b00);
    release_all();
    press_a(1'b0, 1'b0, 2'b01);
    chk("a_wrong_reject", 64'(a_reject), 64'd1);
    chk("a_wrong_board", 64'(a_board), 64'h10000);
    release_all();
    press_a(1'b0, 1'b0, 2'b11);
    chk("a_both_reject", 64'(a_reject), 64'd1);
    chk("a_both_valid", 64'(a_mv), 64'd0);
    release_all();
    a_turn_en = 1'b0;
    press_a(1'b0, 1'b0, 2'b10);
    chk("a_noturn_reject", 64'(a_reject), 64'd0);
    chk("a_noturn_board", 64'(a_board), 64'h10000);
    chk("a_noturn_valid", 64'(a_mv), 64'd0);
    release_all();

    a_turn_en = 1'b1;
    press_a(1'b1, 1'b0, 2'b10);
    chk("a_mark1_board", 64'(a_board), 64'h18000);
    chk("a_mark1_idx", 64'(a_midx), 64'd7);
    chk("a_mark1_player", 64'(a_mplayer), 64'd1);
    chk("a_mark1_cursor", 64'(a_cursor), 64'd6);
    chk("a_mark1_filled", 64'(a_filled), 64'd2);
    release_all();

    a_turn = 1'b0;
    press_a(1'b0, 1'b0, 2'b01);
    chk("a_pend_reject", 64'(a_reject), 64'd1);
    chk("a_pend_board", 64'(a_board), 64'h18000);
    chk("a_pend_valid", 64'(a_mv), 64'd1);
    release_all();

    a_clr = 1'b1; tick(1); a_clr = 1'b0;
    chk("a_clr_board", 64'(a_board), 64'd0);
    chk("a_clr_valid", 64'(a_mv), 64'd0);
    chk("a_clr_cursor", 64'(a_cursor), 64'd8);
    chk("a_clr_filled", 64'(a_filled), 64'd0);

    // Fill the 4x5 board, marking and stepping in the same press each time.
    b_turn_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      p   = k % 3;
      idx = 19 - k;
      b_turn = 2'(p);
      press_b(1'b1, 1'b0, 3'(1 << p));
      chk("b_fill_idx", 64'(b_midx), 64'(idx));
      chk("b_fill_valid", 64'(b_mv), 64'd1);
      release_all();
      b_ack = 1'b1; tick(1); b_ack = 1'b0;
      b_exp[idx*2 +: 2] = 2'(p + 1);
      if (k == 18) chk("b_not_full", 64'(b_full), 64'd0);
    end
    chk("b_fill_board", 64'(b_board), 64'(b_exp));
    chk("b_fill_filled", 64'(b_filled), 64'd20);
    chk("b_fill_full", 64'(b_full), 64'd1);
    chk("b_fill_cursor", 64'(b_cursor), 64'd19);

    step_to_b(2);
    press_b(1'b0, 1'b1, 3'b000);
    chk("b_row_wrap", 64'(b_cursor), 64'd17);
    release_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
